spike_synapse: RTL and testbench

- Receiving end of the neuron's digital spike output. Converts spike events on digital_sel_out into a decaying synaptic current that feeds the I_in input of a downstream neuron.
- Current model: rising edge on spike_in adds a signed weight to a current accumulator. The accumulator decays exponentially toward zero on a fixed tick. A refractory window drops closely spaced spikes.
- Pure digital fixed-point block; runs on the emulator clock alongside the neuron model.

---
 rtl/spike_synapse.sv | 148 ++++++++++++++
 tb/tb_spike_synapse.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/spike_synapse.sv
// Spike-driven synapse: rising edges on spike_in add a signed weight to a saturating,
// exponentially decaying current. Optional accepted-spike counter: SYNAPSE_SPIKE_CNT_EN.
module spike_synapse #(
  parameter int unsigned W             = 16,
  parameter int unsigned DECAY_SHIFT   = 4,
  parameter int unsigned DECAY_PERIOD  = 4,
  parameter int unsigned REFRAC_CYCLES = 8,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                emu_clk,
  input  logic                emu_rst,
  input  logic                spike_in,
  input  logic signed [W-1:0] weight,
  output logic signed [W-1:0] i_out,
  output logic                accept_pulse,
  output logic                drop_pulse,
  output logic                busy
`ifdef SYNAPSE_SPIKE_CNT_EN
  ,
  output logic [CNT_W-1:0]    spike_cnt
`endif
);

  localparam int unsigned DecW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam int unsigned RefW = (REFRAC_CYCLES > 1) ? $clog2(REFRAC_CYCLES) : 1;
  localparam logic [DecW-1:0] DecLast = DecW'(DECAY_PERIOD - 1);
  localparam logic [RefW-1:0] RefLoad = RefW'((REFRAC_CYCLES > 0) ? REFRAC_CYCLES - 1 : 0);

  // Elaboration-time parameter sanity checks.
  if (DECAY_SHIFT < 1 || DECAY_SHIFT > W - 1) begin : g_bad_shift
    $error("spike_synapse: DECAY_SHIFT out of range");
  end
  if (DECAY_PERIOD < 1) begin : g_bad_period
    $error("spike_synapse: DECAY_PERIOD must be at least 1");
  end
  if (CNT_W < 1 || W < 2) begin : g_bad_width
    $error("spike_synapse: W and CNT_W too small");
  end

  typedef enum logic [0:0] {StIdle, StRefrac} state_e;

  state_e                state_q, state_d;
  logic [RefW-1:0]       refrac_q, refrac_d;
  logic [DecW-1:0]       dec_cnt_q, dec_cnt_d;
  logic signed [W-1:0]   i_out_q, i_out_d;
  logic                  spike_q;
  logic                  accept_q, drop_q;
  logic                  accept, drop;
  logic                  spike_edge;
  logic                  tick;

  logic signed [W-1:0]   shr;
  logic signed [W-1:0]   dec_amt;
  logic signed [W-1:0]   decayed;
  logic signed [W:0]     sum;

  assign spike_edge = spike_in & ~spike_q;
  assign tick       = (dec_cnt_q == DecLast);

  // Refractory FSM; also decides accept/drop for this cycle.
  always_comb begin
    state_d  = state_q;
    refrac_d = refrac_q;
    accept   = 1'b0;
    drop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (spike_edge) begin
          accept = 1'b1;
          if (REFRAC_CYCLES > 0) begin
            state_d  = StRefrac;
            refrac_d = RefLoad;
          end
        end
      end
      StRefrac: begin
        drop = spike_edge;
        if (refrac_q == '0) begin
          state_d = StIdle;
        end else begin
          refrac_d = refrac_q - RefW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign dec_cnt_d = tick ? '0 : dec_cnt_q + DecW'(1);

  // Decay first, then add the weight, then clamp to the W-bit signed range.
  always_comb begin
    shr = i_out_q >>> DECAY_SHIFT;
    dec_amt = shr;
    // Small positive values would otherwise stall above zero.
    if (shr == '0 && !i_out_q[W-1] && i_out_q != '0) begin
      dec_amt = {{(W-1){1'b0}}, 1'b1};
    end
    decayed = tick ? (i_out_q - dec_amt) : i_out_q;
    sum = {decayed[W-1], decayed} + (accept ? {weight[W-1], weight} : {(W+1){1'b0}});
    if (sum[W] != sum[W-1]) begin
      i_out_d = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      i_out_d = sum[W-1:0];
    end
  end

  always_ff @(posedge emu_clk) begin
    // Loading spike_in even in reset stops a held-high input from looking like an edge.
    spike_q <= spike_in;
    if (emu_rst) begin
      state_q   <= StIdle;
      refrac_q  <= '0;
      dec_cnt_q <= '0;
      i_out_q   <= '0;
      accept_q  <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      refrac_q  <= refrac_d;
      dec_cnt_q <= dec_cnt_d;
      i_out_q   <= i_out_d;
      accept_q  <= accept;
      drop_q    <= drop;
    end
  end

  assign i_out        = i_out_q;
  assign accept_pulse = accept_q;
  assign drop_pulse   = drop_q;
  assign busy         = (state_q == StRefrac);

`ifdef SYNAPSE_SPIKE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_d = (accept && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign spike_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_spike_synapse.sv
// Directed self-checking bench for spike_synapse with default parameters.
module tb_spike_synapse;

  logic               emu_clk;
  logic               emu_rst;
  logic               spike_in;
  logic signed [15:0] weight;
  logic signed [15:0] i_out;
  logic               accept_pulse;
  logic               drop_pulse;
  logic               busy;
`ifdef SYNAPSE_SPIKE_CNT_EN
  logic [15:0]        spike_cnt;
`endif

  int cyc;
  int total;
  int fails;

  spike_synapse dut (
    .emu_clk      (emu_clk),
    .emu_rst      (emu_rst),
    .spike_in     (spike_in),
    .weight       (weight),
    .i_out        (i_out),
    .accept_pulse (accept_pulse),
    .drop_pulse   (drop_pulse),
`ifdef SYNAPSE_SPIKE_CNT_EN
    .spike_cnt    (spike_cnt),
`endif
    .busy         (busy)
  );

  initial emu_clk = 1'b0;
  always #5 emu_clk = ~emu_clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Advance one clock edge; sample/drive 1 time unit after it.
  task automatic tick1();
    @(posedge emu_clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick1();
  endtask

  task automatic do_reset();
    emu_rst  = 1'b1;
    spike_in = 1'b0;
    tick1();
    tick1();
    emu_rst = 1'b0;
    cyc = 0;
  endtask

  logic signed [15:0] prev;
  bit                 flag;

  initial begin
    total = 0;
    fails = 0;
    cyc = 0;
    emu_rst = 1'b1;
    spike_in = 1'b1;
    weight = 16'sd0;

    // Reset with spike_in held high.
    tick1();
    tick1();
    chk("rst_i_out", i_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_accept", accept_pulse, 0);
    chk("rst_drop", drop_pulse, 0);
    emu_rst = 1'b0;
    cyc = 0;
    run_to(1);
    chk("held_high_no_accept_e1", accept_pulse, 0);
    run_to(2);
    chk("held_high_no_accept_e2", accept_pulse, 0);

    // Single edge at E4 (also a decay tick, but i_out is 0 then).
    spike_in = 1'b0;
    weight = 16'sd1000;
    run_to(3);
    spike_in = 1'b1;
    run_to(4);
    chk("single_accept", accept_pulse, 1);
    chk("single_i_out", i_out, 1000);
    chk("single_busy", busy, 1);
    spike_in = 1'b0;
    run_to(5);
    chk("accept_one_cycle", accept_pulse, 0);
    chk("hold_between_ticks", i_out, 1000);
    run_to(6);
    spike_in = 1'b1;
    run_to(7);
    chk("refrac_drop", drop_pulse, 1);
    chk("refrac_no_accept", accept_pulse, 0);
    chk("refrac_no_weight", i_out, 1000);
    spike_in = 1'b0;
    run_to(8);
    chk("drop_one_cycle", drop_pulse, 0);
    chk("first_decay", i_out, 938);
    chk("busy_mid", busy, 1);
    run_to(11);
    chk("busy_last", busy, 1);
    spike_in = 1'b1;
    run_to(12);
    chk("drop_at_cnt0", drop_pulse, 1);
    chk("busy_clear", busy, 0);
    chk("decay_e12", i_out, 880);
    spike_in = 1'b0;
    run_to(13);
    spike_in = 1'b1;
    run_to(14);
    chk("late_accept", accept_pulse, 1);
    chk("late_i_out", i_out, 1880);
    chk("late_busy", busy, 1);
`ifdef SYNAPSE_SPIKE_CNT_EN
    chk("spike_cnt_two", spike_cnt, 2);
`endif

    // Reset while in REFRAC.
    emu_rst = 1'b1;
    spike_in = 1'b0;
    tick1();
    chk("midrst_busy", busy, 0);
    chk("midrst_i_out", i_out, 0);
    chk("midrst_accept", accept_pulse, 0);
`ifdef SYNAPSE_SPIKE_CNT_EN
    chk("midrst_spike_cnt", spike_cnt, 0);
`endif
    do_reset();

    // Positive saturation: 20000 -> 18750 -> 17579 -> 16481 + 20000 clamps.
    weight = 16'sd20000;
    run_to(1);
    spike_in = 1'b1;
    run_to(2);
    chk("sat_pos_first", i_out, 20000);
    spike_in = 1'b0;
    run_to(11);
    spike_in = 1'b1;
    run_to(12);
    chk("sat_pos_clamp", i_out, 32767);
    chk("sat_pos_accept", accept_pulse, 1);
    do_reset();

    // Negative saturation: -20000 -> -18750 -> -17578 -> -16479 - 20000 clamps.
    weight = -16'sd20000;
    run_to(1);
    spike_in = 1'b1;
    run_to(2);
    chk("sat_neg_first", i_out, -20000);
    spike_in = 1'b0;
    run_to(11);
    spike_in = 1'b1;
    run_to(12);
    chk("sat_neg_clamp", i_out, -32768);
    do_reset();

    // Negative decay to exactly zero.
    weight = -16'sd500;
    run_to(1);
    spike_in = 1'b1;
    run_to(2);
    spike_in = 1'b0;
    chk("neg_start", i_out, -500);
    run_to(4);
    chk("neg_first_decay", i_out, -468);
    prev = i_out;
    flag = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      tick1();
      if (i_out < prev || i_out > 16'sd0) flag = 1'b0;
      prev = i_out;
      if (i_out == 16'sd0) break;
    end
    chk("neg_monotonic", flag, 1);
    chk("neg_reaches_zero", i_out, 0);
    flag = 1'b1;
    repeat (20) begin
      tick1();
      if (i_out !== 16'sd0) flag = 1'b0;
    end
    chk("neg_holds_zero", flag, 1);
    do_reset();

    // Small positive value decays by 1 per tick.
    weight = 16'sd3;
    run_to(1);
    spike_in = 1'b1;
    run_to(2);
    spike_in = 1'b0;
    chk("small_start", i_out, 3);
    run_to(4);
    chk("small_tick1", i_out, 2);
    run_to(8);
    chk("small_tick2", i_out, 1);
    run_to(12);
    chk("small_tick3", i_out, 0);
    run_to(16);
    chk("small_hold", i_out, 0);
    do_reset();

    // Edge on a decay tick: 181 -> 170 -> 160, then 160 - 10 + 100.
    weight = 16'sd181;
    run_to(1);
    spike_in = 1'b1;
    run_to(2);
    spike_in = 1'b0;
    run_to(4);
    chk("coinc_pre1", i_out, 170);
    run_to(8);
    chk("coinc_pre2", i_out, 160);
    weight = 16'sd100;
    run_to(11);
    spike_in = 1'b1;
    run_to(12);
    chk("coinc_i_out", i_out, 250);
    chk("coinc_accept", accept_pulse, 1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
